rr_mux4: RTL
============

Name: rr_mux4

Overview:
- 4-to-1 round-robin multiplexer with valid/ready handshakes on every channel.
- Merges four requester lanes into one registered output stream.
- Tags each beat with its 2-bit source channel (`out_sel`), so a downstream 1:4 demux can route responses back by the same select encoding.
- Sits at the collection point of four producers feeding one shared consumer.

Parameters:
- DW, 8, data width per channel and on the output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  4*DW  channel k data at bits [k*DW +: DW].
- in_valid  input  4  per-channel valid.
- in_last  input  4  per-channel end-of-packet marker.
- in_ready  output  4  per-channel ready; at most one bit high per cycle.
- out_data  output  DW  registered selected data.
- out_sel  output  2  source channel of current output beat (00 = ch0 … 11 = ch3).
- out_last  output  1  in_last of current output beat.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts beat.

Behaviour:
- Single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - out_valid=0, out_data=0, out_sel=2'b00, out_last=0.
  - Round-robin pointer ptr=2'd3, so ch0 has first priority.
  - Lock state (if compiled) cleared.
  - in_ready=0 while rst_n=0.
- One-entry output register; state is EMPTY (out_valid=0) or FULL (out_valid=1).
- load_en = !out_valid || out_ready. Simultaneous drain and load is allowed, giving 1 beat/cycle throughput.
- Arbitration (combinational):
  - Search order starts at ptr+1 (mod 4) and wraps.
  - Grant g is the first k with in_valid[k]=1.
  - No requesters means no grant.
- in_ready[k] = load_en && grant_valid && (g==k).
  - in_ready never depends on out_valid of other blocks beyond out_ready.
  - No channel that is not granted is ever readied.
- Transfer on channel k occurs when in_valid[k] && in_ready[k]. Next cycle:
  - out_data=in_data[k], out_sel=k, out_last=in_last[k], out_valid=1, ptr=k.
- Latency: input handshake cycle N gives the beat on the output at cycle N+1.
- Output drain without new load: out_valid -> 0. out_data/out_sel/out_last hold their last values.
- Backpressure: while out_valid=1 && out_ready=0:
  - out_data, out_sel, out_last held stable.
  - All in_ready=0.
  - ptr unchanged.
- Inputs are assumed compliant: valid is held until ready. The block does not drop a granted beat.
- Fairness: with all four valid continuously and out_ready=1, grant order is 0,1,2,3,0,… with no channel starved beyond 3 beats.
- Reset asserted mid-operation: output beat discarded immediately (out_valid=0 asynchronously), ptr=3, lock cleared. No in_ready until rst_n deasserts; first grant is on the first clk edge after release.
- Pointer wrap: ptr=3 search order is 0,1,2,3.

Optional Feature:
- Macro: RR_MUX4_LOCK_EN.
- With the macro defined (packet lock):
  - When a beat with in_last=0 is transferred from channel k, the arbiter locks to k.
  - While locked, the grant is forced to k if in_valid[k]=1, else no grant. Other channels are held not-ready.
  - Lock releases after the transfer of a beat from k with in_last=1.
  - ptr updates normally on each transfer.
- Without the macro:
  - Per-beat arbitration. in_last only forwarded to out_last, with no effect on grant.
  - No lock register is synthesized.

Decomposition:
- Package rr_mux4_pkg:
  - NCH=4, SEL_W=2.
  - Typedef sel_t (logic [1:0]).
  - Enum out_state_t {EMPTY, FULL}.
- Sub-module rr_arb4: purely combinational.
  - Inputs: req[3:0], ptr[1:0], lock_en, lock_ch.
  - Outputs: grant_valid, grant[1:0].
- rr_mux4 holds the registers, handshake, and lock logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, in_ready=4'b0000 immediately. After release with in_valid=4'b1111 -> first out_sel=00.
- Single channel: only in_valid[2]=1, data 8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=A5, out_sel=10, out_valid=1. Streaming holds 1 beat/cycle.
- Fairness: all valid, data = channel index, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, with out_data matching.
- Backpressure: out_valid=1 (ch1, 8'h3C), out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 -> the next grant is ch2, loaded in the same cycle.
- Lock (RR_MUX4_LOCK_EN): ch0 sends 3 beats (in_last 0,0,1) while ch1 is valid -> out_sel=00,00,00, then 01. Without the macro -> 00,01,00,01 interleaved.
- Idle gap: all in_valid=0 after one beat -> out_valid drops the cycle after the drain. ptr retained, so the next request from ch3 (ptr=2) is granted first over ch0.

Source files
------------

// File: rtl/rr_mux4_pkg.sv
// Shared types for the rr_mux4 4-to-1 round-robin merge.
// Optional packet lock is enabled with RR_MUX4_LOCK_EN.
package rr_mux4_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter with optional forced grant.
// Search starts one past ptr and wraps; lock_en pins the grant to lock_ch.
module rr_arb4
    import rr_mux4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       lock_en,
    input  logic [1:0] lock_ch,
    output logic       grant_valid,
    output logic [1:0] grant
);

    sel_t idx;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        if (lock_en) begin
            grant_valid = req[lock_ch];
            grant       = lock_ch;
        end else begin
            // i == NCH wraps back to ptr itself, the lowest priority
            for (int i = 1; i <= NCH; i++) begin
                idx = ptr + sel_t'(i);
                if (!grant_valid && req[idx]) begin
                    grant_valid = 1'b1;
                    grant       = idx;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux4.sv
// 4-to-1 round-robin mux into a one-entry registered output stage.
// Define RR_MUX4_LOCK_EN to hold the grant until a packet's last beat.
module rr_mux4
    import rr_mux4_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4*DW-1:0] in_data,
    input  logic [3:0]      in_valid,
    input  logic [3:0]      in_last,
    output logic [3:0]      in_ready,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_sel,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready
);

    out_state_t    state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    sel_t          sel_q, sel_d;
    logic          last_q, last_d;
    sel_t          ptr_q, ptr_d;

    logic          load_en;
    logic          xfer;
    logic          gnt_valid;
    sel_t          gnt;
    logic [DW-1:0] gnt_data;
    logic          lock_act;
    sel_t          lock_ch;

`ifdef RR_MUX4_LOCK_EN
    logic lock_q, lock_d;
    sel_t lock_ch_q, lock_ch_d;

    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            lock_d    = !in_last[gnt];
            lock_ch_d = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign lock_act = lock_q;
    assign lock_ch  = lock_ch_q;
`else
    assign lock_act = 1'b0;
    assign lock_ch  = '0;
`endif

    rr_arb4 u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .lock_en     (lock_act),
        .lock_ch     (lock_ch),
        .grant_valid (gnt_valid),
        .grant       (gnt)
    );

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_last  = last_q;

    assign load_en = !out_valid || out_ready;
    // rst_n gate keeps every lane unready for the whole reset window
    assign xfer    = load_en && gnt_valid && rst_n;
    assign in_ready = xfer ? (4'b0001 << gnt) : 4'b0000;

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt == sel_t'(k)) begin
                gnt_data = in_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            state_d = xfer ? FULL : EMPTY;
        end
        if (xfer) begin
            data_d = gnt_data;
            sel_d  = gnt;
            last_d = in_last[gnt];
            ptr_d  = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
